// File: rtl/nasti_lite_mem_slave.sv
// nasti_lite_mem_slave
// Word-addressed on-chip memory terminating the lite side of the NASTI bridge.
// Single-beat AR/AW/W requests, R/B responses with echoed id/user, byte-strobe
// writes, SLVERR for addresses beyond the storage. Read and write paths are
// fully independent of each other.
//
// Handshake semantics (every channel): a transfer happens on a rising edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge. Ready never depends combinationally on the valid of
// the same or another channel; the only combinational ready term is
// lite_ar_ready depending on lite_r_ready.
module nasti_lite_mem_slave #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1,
    parameter int DEPTH      = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,

    // read request
    input  logic [ID_WIDTH-1:0]       lite_ar_id,
    input  logic [ADDR_WIDTH-1:0]     lite_ar_addr,
    input  logic [2:0]                lite_ar_prot,
    input  logic [3:0]                lite_ar_qos,
    input  logic [3:0]                lite_ar_region,
    input  logic [USER_WIDTH-1:0]     lite_ar_user,
    input  logic                      lite_ar_valid,
    output logic                      lite_ar_ready,

    // read response
    output logic [ID_WIDTH-1:0]       lite_r_id,
    output logic [DATA_WIDTH-1:0]     lite_r_data,
    output logic [1:0]                lite_r_resp,
    output logic [USER_WIDTH-1:0]     lite_r_user,
    output logic                      lite_r_valid,
    input  logic                      lite_r_ready,

    // write address
    input  logic [ID_WIDTH-1:0]       lite_aw_id,
    input  logic [ADDR_WIDTH-1:0]     lite_aw_addr,
    input  logic [2:0]                lite_aw_prot,
    input  logic [3:0]                lite_aw_qos,
    input  logic [3:0]                lite_aw_region,
    input  logic [USER_WIDTH-1:0]     lite_aw_user,
    input  logic                      lite_aw_valid,
    output logic                      lite_aw_ready,

    // write data
    input  logic [DATA_WIDTH-1:0]     lite_w_data,
    input  logic [DATA_WIDTH/8-1:0]   lite_w_strb,
    input  logic [USER_WIDTH-1:0]     lite_w_user,
    input  logic                      lite_w_valid,
    output logic                      lite_w_ready,

    // write response
    output logic [ID_WIDTH-1:0]       lite_b_id,
    output logic [1:0]                lite_b_resp,
    output logic [USER_WIDTH-1:0]     lite_b_user,
    output logic                      lite_b_valid,
    input  logic                      lite_b_ready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFF        = $clog2(STRB_WIDTH);
    localparam int IDX        = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Any address bit above the storage window marks a decode error.
    function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
        return (a >> (OFF + IDX)) != '0;
    endfunction

    // Storage; intentionally not reset so contents survive rstn.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic           ar_hs;
    logic           ar_err;
    logic [IDX-1:0] ar_idx;

    assign ar_idx        = lite_ar_addr[OFF+IDX-1:OFF];
    assign ar_err        = addr_err(lite_ar_addr);
    assign lite_ar_ready = !lite_r_valid || lite_r_ready;
    assign ar_hs         = lite_ar_valid && lite_ar_ready;

    // R output register: loads on AR handshake, drains on R handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lite_r_valid <= 1'b0;
            lite_r_id    <= '0;
            lite_r_data  <= '0;
            lite_r_resp  <= '0;
            lite_r_user  <= '0;
        end else if (ar_hs) begin
            lite_r_valid <= 1'b1;
            lite_r_id    <= lite_ar_id;
            lite_r_user  <= lite_ar_user;
            lite_r_data  <= ar_err ? '0 : mem[ar_idx];
            lite_r_resp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
        end else if (lite_r_ready) begin
            lite_r_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Write path: AW and W are captured independently, then committed
    // together once the B slot is free (or being freed this cycle).
    // ------------------------------------------------------------------
    logic                  aw_full;
    logic [ID_WIDTH-1:0]   aw_id_q;
    logic [IDX-1:0]        aw_idx_q;
    logic                  aw_err_q;
    logic [USER_WIDTH-1:0] aw_user_q;

    logic                  w_full;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  commit;

    assign lite_aw_ready = !aw_full;
    assign lite_w_ready  = !w_full;
    assign aw_hs         = lite_aw_valid && lite_aw_ready;
    assign w_hs          = lite_w_valid && lite_w_ready;
    assign commit        = aw_full && w_full && (!lite_b_valid || lite_b_ready);

    // AW holding register; the address is decoded at capture time.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_full   <= 1'b0;
            aw_id_q   <= '0;
            aw_idx_q  <= '0;
            aw_err_q  <= 1'b0;
            aw_user_q <= '0;
        end else if (commit) begin
            aw_full <= 1'b0;
        end else if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_id_q   <= lite_aw_id;
            aw_idx_q  <= lite_aw_addr[OFF+IDX-1:OFF];
            aw_err_q  <= addr_err(lite_aw_addr);
            aw_user_q <= lite_aw_user;
        end
    end

    // W holding register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_full <= 1'b0;
        end else if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= lite_w_data;
            w_strb_q <= lite_w_strb;
        end
    end

    // B response register: a commit (re)loads it, otherwise it drains on ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lite_b_valid <= 1'b0;
            lite_b_id    <= '0;
            lite_b_resp  <= '0;
            lite_b_user  <= '0;
        end else if (commit) begin
            lite_b_valid <= 1'b1;
            lite_b_id    <= aw_id_q;
            lite_b_user  <= aw_user_q;
            lite_b_resp  <= aw_err_q ? RESP_SLVERR : RESP_OKAY;
        end else if (lite_b_ready) begin
            lite_b_valid <= 1'b0;
        end
    end

    // Byte-lane memory write on commit; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        if (commit && !aw_err_q) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (w_strb_q[i]) begin
                    mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
                end
            end
        end
    end

    // Sideband fields and sub-word address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{lite_ar_prot, lite_ar_qos, lite_ar_region,
                             lite_aw_prot, lite_aw_qos, lite_aw_region,
                             lite_w_user, lite_ar_addr[OFF-1:0],
                             lite_aw_addr[OFF-1:0]};

endmodule

// File: tb/tb_nasti_lite_mem_slave.sv
// Testbench for nasti_lite_mem_slave: table of directed write/read vectors
// followed by hand-written multi-cycle sequences.
module tb_nasti_lite_mem_slave;

    localparam int ID_W = 4;
    localparam int AD_W = 13;
    localparam int DW   = 32;
    localparam int UW   = 1;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic [ID_W-1:0] lite_ar_id;
    logic [AD_W-1:0] lite_ar_addr;
    logic [2:0]      lite_ar_prot;
    logic [3:0]      lite_ar_qos;
    logic [3:0]      lite_ar_region;
    logic [UW-1:0]   lite_ar_user;
    logic            lite_ar_valid;
    logic            lite_ar_ready;
    logic [ID_W-1:0] lite_r_id;
    logic [DW-1:0]   lite_r_data;
    logic [1:0]      lite_r_resp;
    logic [UW-1:0]   lite_r_user;
    logic            lite_r_valid;
    logic            lite_r_ready;
    logic [ID_W-1:0] lite_aw_id;
    logic [AD_W-1:0] lite_aw_addr;
    logic [2:0]      lite_aw_prot;
    logic [3:0]      lite_aw_qos;
    logic [3:0]      lite_aw_region;
    logic [UW-1:0]   lite_aw_user;
    logic            lite_aw_valid;
    logic            lite_aw_ready;
    logic [DW-1:0]   lite_w_data;
    logic [DW/8-1:0] lite_w_strb;
    logic [UW-1:0]   lite_w_user;
    logic            lite_w_valid;
    logic            lite_w_ready;
    logic [ID_W-1:0] lite_b_id;
    logic [1:0]      lite_b_resp;
    logic [UW-1:0]   lite_b_user;
    logic            lite_b_valid;
    logic            lite_b_ready;

    nasti_lite_mem_slave dut (
        .clk            (clk),
        .rstn           (rstn),
        .lite_ar_id     (lite_ar_id),
        .lite_ar_addr   (lite_ar_addr),
        .lite_ar_prot   (lite_ar_prot),
        .lite_ar_qos    (lite_ar_qos),
        .lite_ar_region (lite_ar_region),
        .lite_ar_user   (lite_ar_user),
        .lite_ar_valid  (lite_ar_valid),
        .lite_ar_ready  (lite_ar_ready),
        .lite_r_id      (lite_r_id),
        .lite_r_data    (lite_r_data),
        .lite_r_resp    (lite_r_resp),
        .lite_r_user    (lite_r_user),
        .lite_r_valid   (lite_r_valid),
        .lite_r_ready   (lite_r_ready),
        .lite_aw_id     (lite_aw_id),
        .lite_aw_addr   (lite_aw_addr),
        .lite_aw_prot   (lite_aw_prot),
        .lite_aw_qos    (lite_aw_qos),
        .lite_aw_region (lite_aw_region),
        .lite_aw_user   (lite_aw_user),
        .lite_aw_valid  (lite_aw_valid),
        .lite_aw_ready  (lite_aw_ready),
        .lite_w_data    (lite_w_data),
        .lite_w_strb    (lite_w_strb),
        .lite_w_user    (lite_w_user),
        .lite_w_valid   (lite_w_valid),
        .lite_w_ready   (lite_w_ready),
        .lite_b_id      (lite_b_id),
        .lite_b_resp    (lite_b_resp),
        .lite_b_user    (lite_b_user),
        .lite_b_valid   (lite_b_valid),
        .lite_b_ready   (lite_b_ready)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0]   exp_q[$];
    logic [ID_W-1:0] exp_id_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- driver tasks ----------------
    // Wait (bounded) for a B beat and check latency relative to t0 and payload.
    task automatic wait_b(input string tag, input int t0, input logic [ID_W-1:0] id,
                          input logic [1:0] resp, input logic [UW-1:0] user);
        int n;
        n = 0;
        @(negedge clk);
        while (!lite_b_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_b_valid", tag), lite_b_valid, 1'b1);
        check($sformatf("%s_b_latency", tag), cyc - t0, 2);
        check($sformatf("%s_b_id", tag), lite_b_id, id);
        check($sformatf("%s_b_resp", tag), lite_b_resp, resp);
        check($sformatf("%s_b_user", tag), lite_b_user, user);
    endtask

    // AW and W presented in the same cycle on an idle write path.
    task automatic write_pair(input string tag, input logic [ID_W-1:0] id, input logic [AD_W-1:0] addr,
                              input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                              input logic [UW-1:0] user, input logic [1:0] resp);
        int t0;
        @(posedge clk); #1;
        lite_aw_id = id; lite_aw_addr = addr; lite_aw_user = user; lite_aw_valid = 1'b1;
        lite_w_data = data; lite_w_strb = strb; lite_w_valid = 1'b1;
        @(negedge clk);
        check($sformatf("%s_aw_w_ready", tag), {lite_aw_ready, lite_w_ready}, 2'b11);
        t0 = cyc;
        @(posedge clk); #1;
        lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
        wait_b(tag, t0, id, resp, user);
    endtask

    // Single read with r_ready high; expects exactly one cycle of latency.
    task automatic read_one(input string tag, input logic [ID_W-1:0] id, input logic [AD_W-1:0] addr,
                            input logic [UW-1:0] user, input logic [DW-1:0] data, input logic [1:0] resp);
        int t0;
        int n;
        @(posedge clk); #1;
        lite_ar_id = id; lite_ar_addr = addr; lite_ar_user = user; lite_ar_valid = 1'b1;
        @(negedge clk);
        check($sformatf("%s_ar_ready", tag), lite_ar_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        lite_ar_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!lite_r_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s_r_latency", tag), cyc - t0, 1);
        check($sformatf("%s_r_data", tag), lite_r_data, data);
        check($sformatf("%s_r_id", tag), lite_r_id, id);
        check($sformatf("%s_r_resp", tag), lite_r_resp, resp);
        check($sformatf("%s_r_user", tag), lite_r_user, user);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            is_wr;
        logic [ID_W-1:0] id;
        logic [AD_W-1:0] addr;
        logic [DW-1:0]   data;     // write data or expected read data
        logic [3:0]      strb;
        logic [UW-1:0]   user;
        logic [1:0]      resp;     // expected B or R response
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    function automatic logic [DW-1:0] seq_data(input int i);
        return 32'h8000_0000 + i * 32'h0001_0203;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t0;
        int n;
        int sent;
        int got;
        logic [DW-1:0]   ed;
        logic [ID_W-1:0] eid;

        // idle inputs
        lite_ar_id = '0; lite_ar_addr = '0; lite_ar_prot = '0; lite_ar_qos = '0;
        lite_ar_region = '0; lite_ar_user = '0; lite_ar_valid = 1'b0;
        lite_r_ready = 1'b1;
        lite_aw_id = '0; lite_aw_addr = '0; lite_aw_prot = '0; lite_aw_qos = '0;
        lite_aw_region = '0; lite_aw_user = '0; lite_aw_valid = 1'b0;
        lite_w_data = '0; lite_w_strb = '0; lite_w_user = '0; lite_w_valid = 1'b0;
        lite_b_ready = 1'b1;

        //                 wr    id     addr      data          strb  user resp
        vecs[0]  = '{1'b1, 4'h3, 13'h0010, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00};
        vecs[1]  = '{1'b0, 4'h5, 13'h0010, 32'hDEADBEEF, 4'h0, 1'b0, 2'b00};
        vecs[2]  = '{1'b1, 4'h1, 13'h0010, 32'h00001234, 4'h3, 1'b0, 2'b00};
        vecs[3]  = '{1'b0, 4'h2, 13'h0010, 32'hDEAD1234, 4'h0, 1'b1, 2'b00};
        vecs[4]  = '{1'b1, 4'h2, 13'h0000, 32'h11223344, 4'hF, 1'b1, 2'b00};
        vecs[5]  = '{1'b1, 4'h4, 13'h1000, 32'hFFFFFFFF, 4'hF, 1'b0, 2'b10};
        vecs[6]  = '{1'b0, 4'h6, 13'h0000, 32'h11223344, 4'h0, 1'b0, 2'b00};
        vecs[7]  = '{1'b0, 4'h7, 13'h1000, 32'h00000000, 4'h0, 1'b1, 2'b10};
        vecs[8]  = '{1'b1, 4'h9, 13'h0FFC, 32'hA5A55A5A, 4'hF, 1'b1, 2'b00};
        vecs[9]  = '{1'b0, 4'hC, 13'h0FFC, 32'hA5A55A5A, 4'h0, 1'b0, 2'b00};
        vecs[10] = '{1'b1, 4'hE, 13'h0013, 32'hCAFEF00D, 4'hF, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 4'hF, 13'h0010, 32'hCAFEF00D, 4'h0, 1'b1, 2'b00};
        vecs[12] = '{1'b1, 4'h0, 13'h0014, 32'h00000000, 4'hF, 1'b1, 2'b00};
        vecs[13] = '{1'b1, 4'h8, 13'h0014, 32'hAABBCCDD, 4'h5, 1'b0, 2'b00};
        vecs[14] = '{1'b0, 4'h3, 13'h0017, 32'h00BB00DD, 4'h0, 1'b0, 2'b00};
        vecs[15] = '{1'b0, 4'h1, 13'h1FFC, 32'h00000000, 4'h0, 1'b1, 2'b10};
        vecs[16] = '{1'b1, 4'h5, 13'h1FFC, 32'h12345678, 4'hF, 1'b1, 2'b10};
        vecs[17] = '{1'b0, 4'h2, 13'h0000, 32'h11223344, 4'h0, 1'b0, 2'b00};

        // ---- reset state ----
        #12;
        check("rst_r_valid", lite_r_valid, 1'b0);
        check("rst_b_valid", lite_b_valid, 1'b0);
        check("rst_readies", {lite_ar_ready, lite_aw_ready, lite_w_ready}, 3'b111);
        check("rst_r_payload", {lite_r_id, lite_r_data, lite_r_resp, lite_r_user}, '0);
        check("rst_b_payload", {lite_b_id, lite_b_resp, lite_b_user}, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_readies", {lite_ar_ready, lite_aw_ready, lite_w_ready}, 3'b111);

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr)
                write_pair($sformatf("v%0d", i), vecs[i].id, vecs[i].addr, vecs[i].data,
                           vecs[i].strb, vecs[i].user, vecs[i].resp);
            else
                read_one($sformatf("v%0d", i), vecs[i].id, vecs[i].addr, vecs[i].user,
                         vecs[i].data, vecs[i].resp);
        end

        // ---- W three cycles ahead of AW ----
        @(posedge clk); #1;
        lite_w_data = 32'h0BADF00D; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
        @(negedge clk);
        check("wfirst_w_ready", lite_w_ready, 1'b1);
        @(posedge clk); #1;
        lite_w_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("wfirst_no_b", lite_b_valid, 1'b0);
            check("wfirst_w_stall", lite_w_ready, 1'b0);
            @(posedge clk); #1;
        end
        lite_aw_id = 4'hA; lite_aw_addr = 13'h0020; lite_aw_user = 1'b1; lite_aw_valid = 1'b1;
        @(negedge clk);
        check("wfirst_aw_ready", lite_aw_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        lite_aw_valid = 1'b0;
        wait_b("wfirst", t0, 4'hA, 2'b00, 1'b1);

        // ---- AW three cycles ahead of W ----
        @(posedge clk); #1;
        lite_aw_id = 4'hB; lite_aw_addr = 13'h0024; lite_aw_user = 1'b0; lite_aw_valid = 1'b1;
        @(negedge clk);
        check("awfirst_aw_ready", lite_aw_ready, 1'b1);
        @(posedge clk); #1;
        lite_aw_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("awfirst_no_b", lite_b_valid, 1'b0);
            check("awfirst_aw_stall", lite_aw_ready, 1'b0);
            @(posedge clk); #1;
        end
        lite_w_data = 32'h600DCAFE; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
        @(negedge clk);
        check("awfirst_w_ready", lite_w_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        lite_w_valid = 1'b0;
        wait_b("awfirst", t0, 4'hB, 2'b00, 1'b0);
        read_one("wfirst_rd", 4'h4, 13'h0020, 1'b0, 32'h0BADF00D, 2'b00);
        read_one("awfirst_rd", 4'h5, 13'h0024, 1'b1, 32'h600DCAFE, 2'b00);

        // ---- B backpressure with two writes offered ----
        @(posedge clk); #1;
        lite_b_ready = 1'b0;
        lite_aw_id = 4'h1; lite_aw_addr = 13'h0030; lite_aw_user = 1'b0; lite_aw_valid = 1'b1;
        lite_w_data = 32'h11111111; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
        @(negedge clk);
        check("bp_w1_ready", {lite_aw_ready, lite_w_ready}, 2'b11);
        @(posedge clk); #1;
        lite_aw_id = 4'h2; lite_aw_addr = 13'h0034; lite_aw_user = 1'b1;
        lite_w_data = 32'h22222222;
        n = 0;
        @(negedge clk);
        while (!(lite_aw_ready && lite_w_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_w2_captured", {lite_aw_ready, lite_w_ready}, 2'b11);
        @(posedge clk); #1;
        lite_aw_valid = 1'b0; lite_w_valid = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("bp_b_held_valid", lite_b_valid, 1'b1);
            check("bp_b_held_id", lite_b_id, 4'h1);
            check("bp_stall", {lite_aw_ready, lite_w_ready}, 2'b00);
            @(posedge clk); #1;
        end
        lite_b_ready = 1'b1;
        exp_id_q.push_back(4'h1);
        exp_id_q.push_back(4'h2);
        n = 0;
        while (exp_id_q.size() > 0 && n < 20) begin
            @(negedge clk);
            if (lite_b_valid && lite_b_ready) begin
                eid = exp_id_q.pop_front();
                check("bp_b_order_id", lite_b_id, eid);
                check("bp_b_resp", lite_b_resp, 2'b00);
            end
            n++;
        end
        check("bp_all_b_seen", exp_id_q.size(), 0);
        @(negedge clk);
        check("bp_no_extra_b", lite_b_valid, 1'b0);
        read_one("bp_rd1", 4'h6, 13'h0030, 1'b0, 32'h11111111, 2'b00);
        read_one("bp_rd2", 4'h7, 13'h0034, 1'b0, 32'h22222222, 2'b00);

        // ---- 8 back-to-back reads with r_ready toggling ----
        for (int i = 0; i < 8; i++)
            write_pair($sformatf("seq_wr%0d", i), 4'(i), 13'(13'h0040 + 4 * i),
                       seq_data(i), 4'hF, 1'b0, 2'b00);
        @(posedge clk); #1;
        sent = 0; got = 0; n = 0;
        lite_ar_id = 4'h0; lite_ar_addr = 13'h0040; lite_ar_user = 1'b1; lite_ar_valid = 1'b1;
        lite_r_ready = 1'b0;
        while (got < 8 && n < 80) begin
            @(negedge clk);
            if (lite_ar_valid && lite_ar_ready) begin
                exp_q.push_back(seq_data(sent));
                exp_id_q.push_back(4'(sent));
                sent++;
            end
            if (lite_r_valid && lite_r_ready) begin
                if (exp_q.size() == 0) begin
                    check("rr_spurious_r", 1'b1, 1'b0);
                end else begin
                    ed  = exp_q.pop_front();
                    eid = exp_id_q.pop_front();
                    check("rr_data", lite_r_data, ed);
                    check("rr_id", lite_r_id, eid);
                end
                got++;
            end
            @(posedge clk); #1;
            n++;
            if (sent < 8) begin
                lite_ar_addr = 13'(13'h0040 + 4 * sent);
                lite_ar_id   = 4'(sent);
            end else begin
                lite_ar_valid = 1'b0;
            end
            lite_r_ready = n[0];
        end
        lite_ar_valid = 1'b0;
        lite_r_ready  = 1'b1;
        check("rr_count", got, 8);
        check("rr_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("rr_no_dup", lite_r_valid, 1'b0);

        // ---- reset mid-transaction ----
        write_pair("rst_pre_wr", 4'h7, 13'h0060, 32'h5EED5EED, 4'hF, 1'b1, 2'b00);
        @(posedge clk); #1;
        lite_aw_id = 4'h3; lite_aw_addr = 13'h0064; lite_aw_user = 1'b0; lite_aw_valid = 1'b1;
        @(negedge clk);
        check("rst_aw_taken", lite_aw_ready, 1'b1);
        @(posedge clk); #1;
        lite_aw_valid = 1'b0;
        lite_r_ready = 1'b0;
        lite_ar_id = 4'h9; lite_ar_addr = 13'h0060; lite_ar_valid = 1'b1;
        @(negedge clk);
        check("rst_ar_taken", lite_ar_ready, 1'b1);
        @(posedge clk); #1;
        lite_ar_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_r_valid", lite_r_valid, 1'b1);
        check("rst_pre_aw_held", lite_aw_ready, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_async_valids", {lite_r_valid, lite_b_valid}, 2'b00);
        check("rst_async_readies", {lite_ar_ready, lite_aw_ready, lite_w_ready}, 3'b111);
        @(posedge clk); #1;
        rstn = 1'b1;
        lite_r_ready = 1'b1;
        @(negedge clk);
        check("rst_rel_readies", {lite_ar_ready, lite_aw_ready, lite_w_ready}, 3'b111);
        check("rst_rel_valids", {lite_r_valid, lite_b_valid}, 2'b00);
        // A lone W must not pair with the discarded AW.
        @(posedge clk); #1;
        lite_w_data = 32'hFFFFFFFF; lite_w_strb = 4'hF; lite_w_valid = 1'b1;
        @(negedge clk);
        check("rst_w_taken", lite_w_ready, 1'b1);
        @(posedge clk); #1;
        lite_w_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale_b", lite_b_valid, 1'b0);
            @(posedge clk); #1;
        end
        lite_aw_id = 4'hD; lite_aw_addr = 13'h0068; lite_aw_user = 1'b1; lite_aw_valid = 1'b1;
        @(negedge clk);
        check("rst_aw2_taken", lite_aw_ready, 1'b1);
        t0 = cyc;
        @(posedge clk); #1;
        lite_aw_valid = 1'b0;
        wait_b("rst_post", t0, 4'hD, 2'b00, 1'b1);
        read_one("rst_keep_rd", 4'h1, 13'h0060, 1'b0, 32'h5EED5EED, 2'b00);
        read_one("rst_post_rd", 4'h2, 13'h0068, 1'b1, 32'hFFFFFFFF, 2'b00);

        // ---- report ----
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nasti_lite_mem_slave.md
# nasti_lite_mem_slave

NASTI-Lite responder: a word-addressed on-chip memory that terminates the lite side produced by the NASTI/NASTI-Lite bridge. It accepts single-beat AR/AW/W requests and returns R/B responses with echoed ID/user and byte-strobe writes. It serves as the default lite-side endpoint for small peripherals, boot scratch RAM and bridge verification.

## Interface
- ID_WIDTH, 4, request/response ID width
- ADDR_WIDTH, 13, byte address width
- DATA_WIDTH, 32, data width; 32 or 64
- USER_WIDTH, 1, user field width; must be >0
- DEPTH, 1024, words of storage; power of two; DEPTH*DATA_WIDTH/8 ≤ 2^ADDR_WIDTH
- clk  in  1  clock; all logic rising-edge
- rstn  in  1  asynchronous active-low reset
- lite_ar_id / addr / prot / qos / region / user  in  ID_WIDTH / ADDR_WIDTH / 3 / 4 / 4 / USER_WIDTH  read request; prot/qos/region ignored
- lite_ar_valid in 1, lite_ar_ready out 1  read request handshake
- lite_r_id / data / resp / user  out  ID_WIDTH / DATA_WIDTH / 2 / USER_WIDTH  read response
- lite_r_valid out 1, lite_r_ready in 1  read response handshake
- lite_aw_id / addr / prot / qos / region / user  in  same widths as AR  write address; prot/qos/region ignored
- lite_aw_valid in 1, lite_aw_ready out 1  write address handshake
- lite_w_data / strb / user  in  DATA_WIDTH / DATA_WIDTH/8 / USER_WIDTH  write data; w_user ignored
- lite_w_valid in 1, lite_w_ready out 1  write data handshake
- lite_b_id / resp / user  out  ID_WIDTH / 2 / USER_WIDTH  write response
- lite_b_valid out 1, lite_b_ready in 1  write response handshake

## Operation
- OFF = log2(DATA_WIDTH/8); IDX = log2(DEPTH). Word index = addr[OFF+IDX-1:OFF]; addr[OFF-1:0] ignored.
- Decode error: any of addr[ADDR_WIDTH-1:OFF+IDX] nonzero → resp SLVERR (2'b10); otherwise OKAY (2'b00).
- Read path: 1-entry output register. lite_ar_ready = !r_valid || lite_r_ready. On AR handshake, next edge loads r_data = mem[idx] (0 on decode error), r_id = ar_id, r_user = ar_user, r_resp, r_valid = 1. r_valid clears on R handshake with no new AR.
- Write path: independent 1-entry holding registers for AW (id, addr, user) and W (data, strb). lite_aw_ready = !aw_full; lite_w_ready = !w_full. AW and W accepted in any order, including the same cycle.
- Commit condition: aw_full && w_full && (!b_valid || lite_b_ready). On commit edge, byte lanes with strb[i]=1 write mem[idx][8i+7:8i] (suppressed on decode error), aw_full/w_full clear, b_valid sets with b_id = held aw_id, b_user = held aw_user, b_resp.
- b_valid clears on B handshake with no concurrent commit; a concurrent commit reloads it.
- Read and commit to the same word in the same cycle: the read returns old data (read-before-write).
- Storage has no reset; contents are undefined until written and are retained across rstn.

## Timing
- Reset (rstn low, asynchronous): r_valid, b_valid, aw_full, w_full = 0; r_*/b_* payload = 0. Hence aw_ready = w_ready = ar_ready = 1 while in reset and after release.
- Reset mid-transaction discards held AW/W and pending R/B; no memory write is performed for an uncommitted entry.
- Read latency: AR handshake cycle N → r_valid in N+1. With r_ready held high, one read per cycle.
- Write latency: last of AW/W handshake in cycle N → commit at edge ending N+1 → b_valid in N+2. Throughput is one write per 2 cycles. aw_ready/w_ready deassert in N+1.
- B backpressure: with b_valid high and b_ready low, a complete AW+W pair stays held, and further AW/W stall.
- No combinational path from any *_valid input to a *_ready output; ar_ready depends combinationally on lite_r_ready only.
- Read and write paths are fully independent; ordering between them is not guaranteed.

## Test plan
- Write id=3, addr=0x010, data=0xDEADBEEF, strb=0xF, AW and W in the same cycle → b_valid 2 cycles later, b_id=3, b_resp=0; read addr 0x010 id=5 → r_data=0xDEADBEEF, r_id=5, r_resp=0, latency 1.
- Partial strobe: word 0x010=0xDEADBEEF, write data 0x00001234 strb=0x3 → readback 0xDEAD1234.
- W issued 3 cycles before AW, then AW before W → each produces one B with the AW's id and user; memory is updated correctly.
- Out of range (DEPTH=1024, addr=0x1000): write → b_resp=2'b10, word 0 unchanged; read → r_resp=2'b10, r_data=0.
- Backpressure: b_ready=0 for 10 cycles with two writes offered → one B held stable and the second AW/W stalled (ready=0); after b_ready=1, both Bs arrive in order. r_ready toggled during 8 back-to-back reads → all 8 responses are correct, with no drop or duplicate.
- rstn pulsed low while AW is held and r_valid=1 → all valids go to 0 immediately, and all readies go to 1 after release; the prior committed word reads back unchanged.
